reg_writeback_queue: RTL and testbench

Writer-side companion to the multicycle register file. It buffers register writeback requests from long-latency units (load, multiply/divide) in a small in-order FIFO and drains them one per cycle onto the register file's single write port (rd / regwrite / wd3). It also scoreboards pending destinations, so decode can stall on a source register whose write has not yet landed. Sits between the execute/memory stages and the register file write port.

---
 rtl/reg_writeback_queue_pkg.sv | 28 ++
 rtl/reg_writeback_queue_fifo_core.sv | 99 +++++++++
 rtl/reg_writeback_queue.sv | 81 ++++++++
 tb/tb_reg_writeback_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_queue_pkg.sv
// ============================================================================
// reg_writeback_queue_pkg : shared types and constants for the writeback queue
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package reg_writeback_queue_pkg;

  localparam int c_REG_ADDR_W  = 6;
  localparam int c_DEPTH_MIN   = 2;
  localparam int c_DEPTH_MAX   = 16;
  localparam int c_AW_DEF      = 5;
  localparam int c_DATA_W_DEF  = 32;

  // Entry layout for the default configuration (32 registers, 32-bit data).
  typedef struct packed {
    logic [c_AW_DEF-1:0]     rd;
    logic [c_DATA_W_DEF-1:0] data;
  } wb_entry_t;

  function automatic logic depth_ok(input int depth);
    return (depth >= c_DEPTH_MIN) && (depth <= c_DEPTH_MAX) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_writeback_queue_fifo_core.sv
// ============================================================================
// wb_fifo_core : in-order entry storage with head/tail pointers, count and
//                per-entry valid bits; flush clears everything at the next edge
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module wb_fifo_core
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  logic [AW-1:0]           i_push_rd,
  input  logic [DATA_W-1:0]       i_push_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [AW-1:0]           o_head_rd,
  output logic [DATA_W-1:0]       o_head_data,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [DEPTH-1:0]        o_valid,
  output logic [DEPTH*AW-1:0]     o_entry_rd
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;

  logic [c_PW-1:0]   r_head;
  logic [c_PW-1:0]   r_tail;
  logic [c_CW-1:0]   r_count;
  logic [DEPTH-1:0]  r_valid;
  logic [AW-1:0]     r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == c_CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      // Push and pop never target the same slot: pop needs count>0, push needs count<DEPTH.
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + c_PW'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + c_PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through valid/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_tail]   <= i_push_rd;
      r_data[r_tail] <= i_push_data;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign o_entry_rd[gi*AW +: AW] = r_rd[gi];
    end
  endgenerate

  assign o_head_rd   = r_rd[r_head];
  assign o_head_data = r_data[r_head];
  assign o_count     = r_count;
  assign o_valid     = r_valid;

endmodule

`default_nettype wire

// File: rtl/reg_writeback_queue.sv
// ============================================================================
// reg_writeback_queue : buffers long-latency writebacks, drains one per cycle
//                       to the register file port, scoreboards pending rds
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [AW-1:0]           req_rd,
  input  logic [DATA_W-1:0]       req_data,
  input  logic                    wb_hold,
  input  logic                    flush,
  output logic [5:0]              rd,
  output logic                    regwrite,
  output logic [DATA_W-1:0]       wd3,
  input  logic [AW-1:0]           rs1,
  input  logic [AW-1:0]           rs2,
  output logic                    rs1_pending,
  output logic                    rs2_pending,
  output logic [$clog2(DEPTH):0]  count
);

  logic                w_full;
  logic                w_empty;
  logic [AW-1:0]       w_head_rd;
  logic [DATA_W-1:0]   w_head_data;
  logic [DEPTH-1:0]    w_valid;
  logic [DEPTH*AW-1:0] w_entry_rd;
  logic [DEPTH-1:0]    w_hit1;
  logic [DEPTH-1:0]    w_hit2;

  wb_fifo_core #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (req_valid),
    .i_pop       (regwrite),
    .i_flush     (flush),
    .i_push_rd   (req_rd),
    .i_push_data (req_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_count     (count),
    .o_valid     (w_valid),
    .o_entry_rd  (w_entry_rd)
  );

  // Ready looks only at the registered count, so wb_hold never reaches it.
  assign req_ready = !w_full;
  assign regwrite  = !w_empty && !wb_hold && !flush;
  assign rd        = w_empty ? '0 : c_REG_ADDR_W'(w_head_rd);
  assign wd3       = w_empty ? '0 : w_head_data;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign w_hit1[gi] = w_valid[gi] && (w_entry_rd[gi*AW +: AW] == rs1);
      assign w_hit2[gi] = w_valid[gi] && (w_entry_rd[gi*AW +: AW] == rs2);
    end
  endgenerate

  assign rs1_pending = |w_hit1;
  assign rs2_pending = |w_hit2;

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback_queue.sv
// ============================================================================
// tb_reg_writeback_queue : directed self-checking bench for reg_writeback_queue
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_reg_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int AW     = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     req_rd;
  logic [DATA_W-1:0] req_data;
  logic              wb_hold;
  logic              flush;
  logic [5:0]        rd;
  logic              regwrite;
  logic [DATA_W-1:0] wd3;
  logic [AW-1:0]     rs1;
  logic [AW-1:0]     rs2;
  logic              rs1_pending;
  logic              rs2_pending;
  logic [2:0]        count;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] model_q[$];

  reg_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .wb_hold     (wb_hold),
    .flush       (flush),
    .rd          (rd),
    .regwrite    (regwrite),
    .wd3         (wd3),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_rd = '0; req_data = '0;
    wb_hold = 1'b0; flush = 1'b0; rs1 = '0; rs2 = '0;
    #2;
    check_eq("rst_regwrite", regwrite, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_rd", rd, 0);
    check_eq("rst_wd3", wd3, 0);
    check_eq("rst_pend", {rs1_pending, rs2_pending}, 0);
    #10 rst_n = 1'b1;
    tick();

    // Single request, no same-cycle bypass
    req_valid = 1'b1; req_rd = 5'd5; req_data = 32'hDEADBEEF;
    #1 check_eq("single_nobypass", regwrite, 0);
    tick();
    req_valid = 1'b0;
    check_eq("single_regwrite", regwrite, 1);
    check_eq("single_rd", rd, 6'd5);
    check_eq("single_wd3", wd3, 32'hDEADBEEF);
    check_eq("single_count1", count, 1);
    tick();
    check_eq("single_count0", count, 0);
    check_eq("single_idle", regwrite, 0);

    // Fill under hold
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      req_valid = 1'b1; req_rd = AW'(i); req_data = 32'h100 + i;
      tick();
    end
    req_valid = 1'b0; rs1 = 5'd3; rs2 = 5'd7;
    #1;
    check_eq("full_count", count, 4);
    check_eq("full_ready", req_ready, 0);
    check_eq("full_hold_rw", regwrite, 0);
    check_eq("full_rs1_pend", rs1_pending, 1);
    check_eq("full_rs2_pend", rs2_pending, 0);
    req_valid = 1'b1; req_rd = 5'd8; req_data = 32'hBAD;
    tick();
    req_valid = 1'b0;
    check_eq("full_reject_count", count, 4);
    wb_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check_eq("drain_rw", regwrite, 1);
      check_eq("drain_rd", rd, 6'(i));
      check_eq("drain_wd3", wd3, 32'h100 + i);
      tick();
      check_eq("drain_count", count, 3'(4 - i));
      check_eq("drain_ready", req_ready, 1);
    end
    check_eq("drain_empty_rw", regwrite, 0);

    // Same rd twice: last value wins
    rs1 = 5'd9; rs2 = 5'd3;
    req_valid = 1'b1; req_rd = 5'd9; req_data = 32'h11;
    tick();
    req_data = 32'h22;
    #1;
    check_eq("same_rw1", regwrite, 1);
    check_eq("same_wd3_1", wd3, 32'h11);
    check_eq("same_pend1", rs1_pending, 1);
    check_eq("same_rs2_clear", rs2_pending, 0);
    tick();
    req_valid = 1'b0;
    #1;
    check_eq("same_wd3_2", wd3, 32'h22);
    check_eq("same_pend2", rs1_pending, 1);
    tick();
    check_eq("same_pend_clear", rs1_pending, 0);
    check_eq("same_count", count, 0);

    // Steady enqueue+dequeue at count=2 against a reference queue
    wb_hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1; req_rd = AW'(k); req_data = 32'h500 + k;
      model_q.push_back(32'h500 + k);
      tick();
    end
    wb_hold = 1'b0;
    for (int k = 2; k < 12; k++) begin
      req_valid = 1'b1; req_rd = AW'(k); req_data = 32'h500 + k;
      #1;
      check_eq("stream_rw", regwrite, 1);
      check_eq("stream_wd3", wd3, model_q[0]);
      tick();
      void'(model_q.pop_front());
      model_q.push_back(32'h500 + k);
      check_eq("stream_count", count, 2);
    end
    req_valid = 1'b0;
    while (model_q.size() != 0) begin
      check_eq("stream_tail_wd3", wd3, model_q[0]);
      void'(model_q.pop_front());
      tick();
    end
    check_eq("stream_empty", count, 0);

    // Flush with concurrent request
    wb_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_rd = AW'(20 + k); req_data = 32'h700 + k;
      tick();
    end
    check_eq("pre_flush_count", count, 3);
    wb_hold = 1'b0; flush = 1'b1; req_valid = 1'b1; req_rd = 5'd30; req_data = 32'h999;
    rs1 = 5'd21; rs2 = 5'd30;
    #1 check_eq("flush_rw", regwrite, 0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check_eq("flush_count", count, 0);
    check_eq("flush_pend", {rs1_pending, rs2_pending}, 0);
    check_eq("flush_rw_after", regwrite, 0);

    // Asynchronous reset mid-drain
    wb_hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1; req_rd = AW'(k + 1); req_data = 32'hA0 + k;
      tick();
    end
    req_valid = 1'b0; wb_hold = 1'b0;
    #1 check_eq("prerst_rw", regwrite, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_rw", regwrite, 0);
    check_eq("arst_count", count, 0);
    check_eq("arst_ready", req_ready, 1);
    rst_n = 1'b1;
    tick();
    check_eq("arst_stays_empty", count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
